// File: rtl/arb_fixed_priority_timed.sv
// Fixed-priority arbiter (index 0 wins) with per-requester mask, optional
// absolute (preemptive) mode and a max-hold timeout that locks the timed-out
// requester out of exactly one arbitration.
module arb_fixed_priority_timed #(
  parameter int REQ_NUM  = 4,
  parameter int MODE_ABS = 0,
  parameter int HOLD_MAX = 16,
  parameter int ID_W     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  parameter int CNT_W    = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_NUM-1:0] req,
  input  logic [REQ_NUM-1:0] req_mask,
  output logic [REQ_NUM-1:0] grant,
  output logic               grant_vld,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout_pulse
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  logic [REQ_NUM-1:0] r_grant;
  logic [ID_W-1:0]    r_grant_id;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [REQ_NUM-1:0] r_lockout;

  state_t             w_state;
  logic [REQ_NUM-1:0] w_elig;
  logic [REQ_NUM-1:0] w_win;
  logic               w_hold_req;
  logic               w_timeout_hit;
  logic [REQ_NUM-1:0] w_grant_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [REQ_NUM-1:0] w_lock_nxt;
  logic               w_to_nxt;

  function automatic logic [ID_W-1:0] onehot_to_id(input logic [REQ_NUM-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (oh[i]) id = id | ID_W'(i);
    end
    return id;
  endfunction

  // Hold counter never wraps: it sticks at HOLD_MAX.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    if (HOLD_MAX == 0)                return c;
    else if (c < CNT_W'(HOLD_MAX))    return c + 1'b1;
    else                              return c;
  endfunction

  // The state is implied by whether any grant is currently held.
  assign w_state       = (|r_grant) ? ST_BUSY : ST_IDLE;
  assign w_elig        = req & ~req_mask & ~r_lockout;
  assign w_win         = w_elig & (~w_elig + REQ_NUM'(1));
  // Holder still requesting and unmasked; a drop here is a release, which
  // takes precedence over a simultaneous timeout.
  assign w_hold_req    = |(r_grant & req & ~req_mask);
  assign w_timeout_hit = (HOLD_MAX != 0) && w_hold_req && (r_hold_cnt == CNT_W'(HOLD_MAX));

  // Next grant, hold count, lockout and timeout pulse.
  always_comb begin
    w_grant_nxt = '0;
    w_cnt_nxt   = '0;
    w_lock_nxt  = r_lockout;
    w_to_nxt    = 1'b0;
    case (w_state)
      ST_IDLE: begin
        w_lock_nxt = '0;
        if (|w_elig) begin
          w_grant_nxt = w_win;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      default: begin
        if (w_timeout_hit) begin
          w_lock_nxt = r_grant;
          w_to_nxt   = 1'b1;
        end else if (MODE_ABS != 0) begin
          if (|w_win) begin
            w_grant_nxt = w_win;
            w_cnt_nxt   = (w_win == r_grant) ? cnt_sat_inc(r_hold_cnt) : CNT_W'(1);
          end
        end else if (w_hold_req) begin
          w_grant_nxt = r_grant;
          w_cnt_nxt   = cnt_sat_inc(r_hold_cnt);
        end
      end
    endcase
    if (|w_grant_nxt) w_lock_nxt = '0;
  end

  // Registered outputs and arbitration state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant    <= '0;
      r_grant_id <= '0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= '0;
      r_lockout  <= '0;
    end else begin
      r_grant    <= w_grant_nxt;
      r_grant_id <= onehot_to_id(w_grant_nxt);
      r_timeout  <= w_to_nxt;
      r_hold_cnt <= w_cnt_nxt;
      r_lockout  <= w_lock_nxt;
    end
  end

  assign grant         = r_grant;
  assign grant_vld     = |r_grant;
  assign grant_id      = r_grant_id;
  assign timeout_pulse = r_timeout;

endmodule

// File: tb/tb_arb_fixed_priority_timed.sv
// Directed bench for arb_fixed_priority_timed: four instances cover lock mode,
// preempt mode, timeout in lock mode and timeout in preempt mode.
module tb_arb_fixed_priority_timed;

  logic clk = 1'b0;
  logic rst;
  logic [3:0][3:0] req_v;
  logic [3:0][3:0] mask_v;
  logic [3:0][3:0] grant_v;
  logic [3:0]      vld_v;
  logic [3:0][1:0] id_v;
  logic [3:0]      to_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_fixed_priority_timed #(.REQ_NUM(4), .MODE_ABS(0), .HOLD_MAX(0)) u_lock (
    .clk(clk), .rst(rst), .req(req_v[0]), .req_mask(mask_v[0]),
    .grant(grant_v[0]), .grant_vld(vld_v[0]), .grant_id(id_v[0]), .timeout_pulse(to_v[0]));

  arb_fixed_priority_timed #(.REQ_NUM(4), .MODE_ABS(1), .HOLD_MAX(0)) u_abs (
    .clk(clk), .rst(rst), .req(req_v[1]), .req_mask(mask_v[1]),
    .grant(grant_v[1]), .grant_vld(vld_v[1]), .grant_id(id_v[1]), .timeout_pulse(to_v[1]));

  arb_fixed_priority_timed #(.REQ_NUM(4), .MODE_ABS(0), .HOLD_MAX(4)) u_to (
    .clk(clk), .rst(rst), .req(req_v[2]), .req_mask(mask_v[2]),
    .grant(grant_v[2]), .grant_vld(vld_v[2]), .grant_id(id_v[2]), .timeout_pulse(to_v[2]));

  arb_fixed_priority_timed #(.REQ_NUM(4), .MODE_ABS(1), .HOLD_MAX(4)) u_abs_to (
    .clk(clk), .rst(rst), .req(req_v[3]), .req_mask(mask_v[3]),
    .grant(grant_v[3]), .grant_vld(vld_v[3]), .grant_id(id_v[3]), .timeout_pulse(to_v[3]));

  typedef struct {
    int         sel;
    logic [3:0] req;
    logic [3:0] mask;
    logic [3:0] g;
    logic [1:0] id;
    logic       vld;
    logic       to;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int sel, input logic [3:0] r, input logic [3:0] m,
                     input logic [3:0] g, input logic [1:0] id, input logic vld, input logic to);
    vec_t v;
    v.sel = sel; v.req = r; v.mask = m; v.g = g; v.id = id; v.vld = vld; v.to = to;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d got %b want %b", name, idx, got, exp);
    end
  endtask

  task automatic chk_dut(input string tag, input int idx, input int s, input logic [3:0] g,
                         input logic [1:0] id, input logic vld, input logic to);
    chk({tag, ".grant"}, idx, grant_v[s], g);
    chk({tag, ".grant_id"}, idx, {2'b00, id_v[s]}, {2'b00, id});
    chk({tag, ".grant_vld"}, idx, {3'b000, vld_v[s]}, {3'b000, vld});
    chk({tag, ".timeout_pulse"}, idx, {3'b000, to_v[s]}, {3'b000, to});
  endtask

  initial begin
    rst    = 1'b1;
    req_v  = '0;
    mask_v = '0;

    // Lock mode: holder keeps grant, release gives one bubble.
    add(0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1, 0);
    add(0, 4'b0001, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    // Preempt mode: higher request takes over with no bubble; mask skips.
    add(1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1, 0);
    add(1, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(1, 4'b0011, 4'b0001, 4'b0010, 2'd1, 1, 0);
    add(1, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    // Timeout, lock mode, two requesters alternate.
    for (int i = 0; i < 4; i++) add(2, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(2, 4'b0011, 4'b0000, 4'b0000, 2'd0, 0, 1);
    for (int i = 0; i < 4; i++) add(2, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1, 0);
    add(2, 4'b0011, 4'b0000, 4'b0000, 2'd0, 0, 1);
    add(2, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(2, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    // Lone timeout: bubble plus lockout cycle before re-grant.
    for (int i = 0; i < 4; i++) add(2, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(2, 4'b0001, 4'b0000, 4'b0000, 2'd0, 0, 1);
    add(2, 4'b0001, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(2, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(2, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    // Mask on holder releases; release at hold_cnt==HOLD_MAX gives no pulse.
    add(2, 4'b0011, 4'b0001, 4'b0010, 2'd1, 1, 0);
    add(2, 4'b0011, 4'b0010, 4'b0000, 2'd0, 0, 0);
    add(2, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0);
    for (int i = 0; i < 3; i++) add(2, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(2, 4'b0010, 4'b0000, 4'b0000, 2'd0, 0, 0);
    add(2, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1, 0);
    add(2, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);
    // Preempt mode with timeout: timeout first, then lockout lifts and req 0 preempts.
    for (int i = 0; i < 4; i++) add(3, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(3, 4'b0011, 4'b0000, 4'b0000, 2'd0, 0, 1);
    add(3, 4'b0011, 4'b0000, 4'b0010, 2'd1, 1, 0);
    add(3, 4'b0011, 4'b0000, 4'b0001, 2'd0, 1, 0);
    add(3, 4'b0000, 4'b0000, 4'b0000, 2'd0, 0, 0);

    // Reset state before any clock edge.
    #1;
    for (int s = 0; s < 4; s++) chk_dut("reset", -1, s, 4'b0000, 2'd0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      req_v[tbl[i].sel]  = tbl[i].req;
      mask_v[tbl[i].sel] = tbl[i].mask;
      @(posedge clk);
      #1;
      chk_dut("vec", i, tbl[i].sel, tbl[i].g, tbl[i].id, tbl[i].vld, tbl[i].to);
    end

    // Asynchronous reset mid-grant, then first arbitration after release.
    @(negedge clk);
    req_v[0] = 4'b1000;
    @(posedge clk);
    #1;
    chk_dut("pre_rst", 0, 0, 4'b1000, 2'd3, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    chk_dut("async_rst", 0, 0, 4'b0000, 2'd0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_dut("post_rst", 0, 0, 4'b1000, 2'd3, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
